// File: rtl/sc_core_oz_wb_ctrl_if.sv
// rtl/sc_core_oz_wb_ctrl_if.sv - write-back controller bus bundle (fwd ports under SC_CORE_OZ_WB_BYPASS_EN)
interface sc_core_oz_wb_ctrl_if;
    logic        alu_wr_en;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_wr_data;
    logic        ld_issue_valid;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_issue_funct3;
    logic [1:0]  ld_issue_lsb;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;
    logic [4:0]  dec_rd_addr;
    logic        hazard_stall;
    logic        rd_reg_wr_en;
    logic [4:0]  rd_reg_address;
    logic [31:0] rd_reg_data;
    logic        err_unexp_rsp;
`ifdef SC_CORE_OZ_WB_BYPASS_EN
    logic        rs1_fwd_valid;
    logic [31:0] rs1_fwd_data;
    logic        rs2_fwd_valid;
    logic [31:0] rs2_fwd_data;
`endif

    // Core side: drives results, load traffic and decode addresses
    modport master (
        output alu_wr_en, alu_rd_addr, alu_wr_data,
        output ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_lsb,
        output ld_rsp_valid, ld_rsp_data,
        output dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
        input  ld_issue_ready, hazard_stall,
        input  rd_reg_wr_en, rd_reg_address, rd_reg_data, err_unexp_rsp
`ifdef SC_CORE_OZ_WB_BYPASS_EN
        , input rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
    );

    // Write-back controller side
    modport slave (
        input  alu_wr_en, alu_rd_addr, alu_wr_data,
        input  ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_lsb,
        input  ld_rsp_valid, ld_rsp_data,
        input  dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
        output ld_issue_ready, hazard_stall,
        output rd_reg_wr_en, rd_reg_address, rd_reg_data, err_unexp_rsp
`ifdef SC_CORE_OZ_WB_BYPASS_EN
        , output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
    );
endinterface

// File: rtl/sc_core_oz_wb_ctrl.sv
// rtl/sc_core_oz_wb_ctrl.sv - write-back controller with load scoreboard (option: SC_CORE_OZ_WB_BYPASS_EN)
module sc_core_oz_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    sc_core_oz_wb_ctrl_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Pending queue: loads issued, response not yet seen
    logic [4:0]  pq_rd_q   [DEPTH];
    logic [4:0]  pq_rd_d   [DEPTH];
    logic [2:0]  pq_f3_q   [DEPTH];
    logic [2:0]  pq_f3_d   [DEPTH];
    logic [1:0]  pq_lsb_q  [DEPTH];
    logic [1:0]  pq_lsb_d  [DEPTH];
    // Return buffer: formatted load data waiting for a free write slot
    logic [4:0]  rb_rd_q   [DEPTH];
    logic [4:0]  rb_rd_d   [DEPTH];
    logic [31:0] rb_data_q [DEPTH];
    logic [31:0] rb_data_d [DEPTH];

    logic [PW-1:0] pq_wp_q, pq_wp_d, pq_rp_q, pq_rp_d;
    logic [PW-1:0] rb_wp_q, rb_wp_d, rb_rp_q, rb_rp_d;
    logic [CW-1:0] pq_cnt_q, pq_cnt_d, rb_cnt_q, rb_cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          err_q, err_d;

    logic          ld_ready, pq_push, pq_pop, rb_push, rb_pop, alu_win, hazard;
    logic [4:0]    pq_head_rd;
    logic [31:0]   ld_fmt;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lsb)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lsb[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b100:  fmt_load = {24'd0, b};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = w;
        endcase
    endfunction

    function automatic logic dec_hit(input logic [4:0] r, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] c);
        dec_hit = (r != 5'd0) && ((r == a) || (r == b) || (r == c));
    endfunction

    // Occupancy, handshakes and write-port arbitration decisions
    always_comb begin
        ld_ready   = ({1'b0, pq_cnt_q} + {1'b0, rb_cnt_q}) < (CW + 1)'(DEPTH);
        pq_push    = wb.ld_issue_valid && ld_ready;
        pq_pop     = wb.ld_rsp_valid && (pq_cnt_q != '0);
        pq_head_rd = pq_rd_q[pq_rp_q];
        ld_fmt     = fmt_load(pq_f3_q[pq_rp_q], pq_lsb_q[pq_rp_q], wb.ld_rsp_data);
        // Loads to x0 still hold a slot until their response, but never reach the RB
        rb_push    = pq_pop && (pq_head_rd != 5'd0);
        alu_win    = wb.alu_wr_en && (wb.alu_rd_addr != 5'd0);
        rb_pop     = !alu_win && (rb_cnt_q != '0);
    end

    // Queue next state: pushes, pops and net count changes
    always_comb begin
        pq_rd_d   = pq_rd_q;
        pq_f3_d   = pq_f3_q;
        pq_lsb_d  = pq_lsb_q;
        rb_rd_d   = rb_rd_q;
        rb_data_d = rb_data_q;
        pq_wp_d   = pq_wp_q;
        pq_rp_d   = pq_rp_q;
        rb_wp_d   = rb_wp_q;
        rb_rp_d   = rb_rp_q;
        if (pq_push) begin
            pq_rd_d[pq_wp_q]  = wb.ld_issue_rd;
            pq_f3_d[pq_wp_q]  = wb.ld_issue_funct3;
            pq_lsb_d[pq_wp_q] = wb.ld_issue_lsb;
            pq_wp_d           = pq_wp_q + PW'(1);
        end
        if (pq_pop) begin
            pq_rp_d = pq_rp_q + PW'(1);
        end
        if (rb_push) begin
            rb_rd_d[rb_wp_q]   = pq_head_rd;
            rb_data_d[rb_wp_q] = ld_fmt;
            rb_wp_d            = rb_wp_q + PW'(1);
        end
        if (rb_pop) begin
            rb_rp_d = rb_rp_q + PW'(1);
        end
        pq_cnt_d = pq_cnt_q + CW'(pq_push) - CW'(pq_pop);
        rb_cnt_d = rb_cnt_q + CW'(rb_push) - CW'(rb_pop);
    end

    // Register-file write port and sticky unexpected-response flag
    always_comb begin
        wr_en_d   = alu_win || rb_pop;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (alu_win) begin
            wr_addr_d = wb.alu_rd_addr;
            wr_data_d = wb.alu_wr_data;
        end else if (rb_pop) begin
            wr_addr_d = rb_rd_q[rb_rp_q];
            wr_data_d = rb_data_q[rb_rp_q];
        end
        err_d = err_q || (wb.ld_rsp_valid && (pq_cnt_q == '0));
    end

    // Stall decode on any register still owed by an outstanding or buffered load
    always_comb begin
        hazard = wb.ld_issue_valid && !ld_ready;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(PW'(i) - pq_rp_q) < pq_cnt_q) &&
                dec_hit(pq_rd_q[i], wb.dec_rs1_addr, wb.dec_rs2_addr, wb.dec_rd_addr)) begin
                hazard = 1'b1;
            end
            if ((CW'(PW'(i) - rb_rp_q) < rb_cnt_q) &&
                dec_hit(rb_rd_q[i], wb.dec_rs1_addr, wb.dec_rs2_addr, wb.dec_rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            pq_wp_q   <= '0;
            pq_rp_q   <= '0;
            rb_wp_q   <= '0;
            rb_rp_q   <= '0;
            pq_cnt_q  <= '0;
            rb_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            pq_wp_q   <= pq_wp_d;
            pq_rp_q   <= pq_rp_d;
            rb_wp_q   <= rb_wp_d;
            rb_rp_q   <= rb_rp_d;
            pq_cnt_q  <= pq_cnt_d;
            rb_cnt_q  <= rb_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    // Queue payload storage; validity comes from the counts, so no reset needed
    always_ff @(posedge clk) begin
        pq_rd_q   <= pq_rd_d;
        pq_f3_q   <= pq_f3_d;
        pq_lsb_q  <= pq_lsb_d;
        rb_rd_q   <= rb_rd_d;
        rb_data_q <= rb_data_d;
    end

    assign wb.ld_issue_ready = ld_ready;
    assign wb.hazard_stall   = hazard;
    assign wb.rd_reg_wr_en   = wr_en_q;
    assign wb.rd_reg_address = wr_addr_q;
    assign wb.rd_reg_data    = wr_data_q;
    assign wb.err_unexp_rsp  = err_q;

`ifdef SC_CORE_OZ_WB_BYPASS_EN
    assign wb.rs1_fwd_valid = wr_en_q && (wr_addr_q != 5'd0) && (wr_addr_q == wb.dec_rs1_addr);
    assign wb.rs1_fwd_data  = wr_data_q;
    assign wb.rs2_fwd_valid = wr_en_q && (wr_addr_q != 5'd0) && (wr_addr_q == wb.dec_rs2_addr);
    assign wb.rs2_fwd_data  = wr_data_q;
`endif
endmodule

// File: tb/tb_sc_core_oz_wb_ctrl.sv
// tb/tb_sc_core_oz_wb_ctrl.sv - directed self-checking bench for sc_core_oz_wb_ctrl
module tb_sc_core_oz_wb_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sc_core_oz_wb_ctrl_if wb_if ();

    sc_core_oz_wb_ctrl #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_if.alu_wr_en       = 1'b0;
        wb_if.alu_rd_addr     = 5'd0;
        wb_if.alu_wr_data     = 32'd0;
        wb_if.ld_issue_valid  = 1'b0;
        wb_if.ld_issue_rd     = 5'd0;
        wb_if.ld_issue_funct3 = 3'd0;
        wb_if.ld_issue_lsb    = 2'd0;
        wb_if.ld_rsp_valid    = 1'b0;
        wb_if.ld_rsp_data     = 32'd0;
        wb_if.dec_rs1_addr    = 5'd0;
        wb_if.dec_rs2_addr    = 5'd0;
        wb_if.dec_rd_addr     = 5'd0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb);
        wb_if.ld_issue_valid  = 1'b1;
        wb_if.ld_issue_rd     = rd;
        wb_if.ld_issue_funct3 = f3;
        wb_if.ld_issue_lsb    = lsb;
        tick();
        wb_if.ld_issue_valid  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        wb_if.ld_rsp_valid = 1'b1;
        wb_if.ld_rsp_data  = data;
        tick();
        wb_if.ld_rsp_valid = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, "_wr_en"}, 32'(wb_if.rd_reg_wr_en), 32'd1);
        chk({tag, "_addr"}, 32'(wb_if.rd_reg_address), 32'(rd));
        chk({tag, "_data"}, wb_if.rd_reg_data, data);
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lsb, input logic [31:0] raw, input logic [31:0] exp);
        issue(rd, f3, lsb);
        respond(raw);
        tick();
        expect_wr(tag, rd, exp);
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_wr_en", 32'(wb_if.rd_reg_wr_en), 32'd0);
        chk("rst_addr", 32'(wb_if.rd_reg_address), 32'd0);
        chk("rst_data", wb_if.rd_reg_data, 32'd0);
        chk("rst_err", 32'(wb_if.err_unexp_rsp), 32'd0);
        chk("rst_ready", 32'(wb_if.ld_issue_ready), 32'd1);
        chk("rst_stall", 32'(wb_if.hazard_stall), 32'd0);

        // ALU write, then ALU to x0 (no write, address/data hold)
        wb_if.alu_wr_en   = 1'b1;
        wb_if.alu_rd_addr = 5'd5;
        wb_if.alu_wr_data = 32'h1234_5678;
        tick();
        idle();
        expect_wr("alu5", 5'd5, 32'h1234_5678);
`ifdef SC_CORE_OZ_WB_BYPASS_EN
        wb_if.dec_rs1_addr = 5'd5;
        #1;
        chk("fwd_rs1_valid", 32'(wb_if.rs1_fwd_valid), 32'd1);
        chk("fwd_rs1_data", wb_if.rs1_fwd_data, 32'h1234_5678);
        chk("fwd_rs2_valid", 32'(wb_if.rs2_fwd_valid), 32'd0);
        idle();
`endif
        wb_if.alu_wr_en   = 1'b1;
        wb_if.alu_rd_addr = 5'd0;
        wb_if.alu_wr_data = 32'hDEAD_BEEF;
        tick();
        idle();
        chk("alu0_wr_en", 32'(wb_if.rd_reg_wr_en), 32'd0);
        chk("alu0_addr_hold", 32'(wb_if.rd_reg_address), 32'd5);
        chk("alu0_data_hold", wb_if.rd_reg_data, 32'h1234_5678);

        // Load formatting
        do_load("lb", 5'd3, 3'b000, 2'd2, 32'h00F0_8000, 32'hFFFF_FFF0);
        do_load("lbu", 5'd3, 3'b100, 2'd2, 32'h00F0_8000, 32'h0000_00F0);
        do_load("lh", 5'd4, 3'b001, 2'd0, 32'h00F0_8000, 32'hFFFF_8000);
        do_load("lhu", 5'd6, 3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001);
        do_load("lw_dflt", 5'd8, 3'b011, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Collision: buffered load x9 loses to ALU x7, written one cycle later
        issue(5'd9, 3'b010, 2'd0);
        respond(32'h0000_00AA);
        wb_if.alu_wr_en   = 1'b1;
        wb_if.alu_rd_addr = 5'd7;
        wb_if.alu_wr_data = 32'h0000_0077;
        tick();
        idle();
        expect_wr("col_alu7", 5'd7, 32'h0000_0077);
        tick();
        expect_wr("col_ld9", 5'd9, 32'h0000_00AA);

        // Full scoreboard
        for (int k = 0; k < 4; k++) issue(5'(11 + k), 3'b010, 2'd0);
        chk("full_ready", 32'(wb_if.ld_issue_ready), 32'd0);
        wb_if.ld_issue_valid = 1'b1;
        #1;
        chk("full_stall", 32'(wb_if.hazard_stall), 32'd1);
        wb_if.ld_issue_valid = 1'b0;
        #1;
        respond(32'h0000_0011);
        chk("full_rb_ready", 32'(wb_if.ld_issue_ready), 32'd0);
        chk("full_rb_wr_en", 32'(wb_if.rd_reg_wr_en), 32'd0);
        tick();
        expect_wr("full_x11", 5'd11, 32'h0000_0011);
        chk("full_ready_back", 32'(wb_if.ld_issue_ready), 32'd1);
        for (int k = 0; k < 3; k++) respond(32'(32'h12 + k));
        tick();
        expect_wr("drain_x14", 5'd14, 32'h0000_0014);
        tick();
        chk("drain_idle", 32'(wb_if.rd_reg_wr_en), 32'd0);

        // Hazard tracking on x10
        issue(5'd10, 3'b010, 2'd0);
        wb_if.dec_rs2_addr = 5'd10;
        #1;
        chk("haz_rs2", 32'(wb_if.hazard_stall), 32'd1);
        wb_if.dec_rs2_addr = 5'd0;
        wb_if.dec_rd_addr  = 5'd5;
        #1;
        chk("haz_none", 32'(wb_if.hazard_stall), 32'd0);
        wb_if.dec_rd_addr = 5'd10;
        #1;
        chk("haz_waw", 32'(wb_if.hazard_stall), 32'd1);
        wb_if.dec_rd_addr  = 5'd0;
        wb_if.dec_rs2_addr = 5'd10;
        respond(32'hA5A5_A5A5);
        chk("haz_in_rb", 32'(wb_if.hazard_stall), 32'd1);
        tick();
        expect_wr("haz_x10", 5'd10, 32'hA5A5_A5A5);
        chk("haz_clear", 32'(wb_if.hazard_stall), 32'd0);
        idle();

        // Load to x0: slot consumed, response discarded
        issue(5'd0, 3'b010, 2'd0);
        respond(32'h5555_5555);
        tick();
        chk("x0_no_wr", 32'(wb_if.rd_reg_wr_en), 32'd0);
        chk("x0_ready", 32'(wb_if.ld_issue_ready), 32'd1);
        chk("x0_no_err", 32'(wb_if.err_unexp_rsp), 32'd0);

        // Unexpected response
        respond(32'h0BAD_0BAD);
        chk("unexp_err", 32'(wb_if.err_unexp_rsp), 32'd1);
        tick();
        chk("unexp_sticky", 32'(wb_if.err_unexp_rsp), 32'd1);
        chk("unexp_no_wr", 32'(wb_if.rd_reg_wr_en), 32'd0);

        // Reset with two loads pending
        issue(5'd20, 3'b010, 2'd0);
        issue(5'd21, 3'b010, 2'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wb_if.dec_rs1_addr = 5'd20;
        #1;
        chk("mrst_ready", 32'(wb_if.ld_issue_ready), 32'd1);
        chk("mrst_err", 32'(wb_if.err_unexp_rsp), 32'd0);
        chk("mrst_wr_en", 32'(wb_if.rd_reg_wr_en), 32'd0);
        chk("mrst_stall", 32'(wb_if.hazard_stall), 32'd0);
        idle();
        respond(32'h0000_0020);
        chk("mrst_unexp", 32'(wb_if.err_unexp_rsp), 32'd1);
        tick();
        chk("mrst_no_wr", 32'(wb_if.rd_reg_wr_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sc_core_oz_wb_ctrl.md
Name: sc_core_oz_wb_ctrl

Overview:
- Write-back controller: the initiator side of the register-file write port (rd_reg_wr_en / rd_reg_address / rd_reg_data).
- Merges single-cycle ALU results with delayed, in-order load responses from data memory.
- Formats load data (byte/half/word, sign/zero extension).
- Tracks outstanding loads in a scoreboard and raises a hazard stall to the core front end.

Parameters:
- DEPTH, 4, max outstanding loads (issued-not-returned plus returned-not-written); power of 2, >=2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on rising clk)
- alu_wr_en  in  1  ALU/jump/LUI result valid this cycle
- alu_rd_addr  in  5  ALU destination register
- alu_wr_data  in  32  ALU result
- ld_issue_valid  in  1  load instruction issuing to memory
- ld_issue_ready  out  1  scoreboard can accept a load
- ld_issue_rd  in  5  load destination register
- ld_issue_funct3  in  3  load type (RV32I encoding)
- ld_issue_lsb  in  2  address bits [1:0]
- ld_rsp_valid  in  1  memory read data valid (in issue order, always accepted)
- ld_rsp_data  in  32  raw aligned memory word
- dec_rs1_addr  in  5  decode-stage source 1
- dec_rs2_addr  in  5  decode-stage source 2
- dec_rd_addr  in  5  decode-stage destination
- hazard_stall  out  1  decode instruction must stall
- rd_reg_wr_en  out  1  RF write enable
- rd_reg_address  out  5  RF write address
- rd_reg_data  out  32  RF write data
- err_unexp_rsp  out  1  sticky: response with no outstanding load

Behaviour:
- Reset: rd_reg_wr_en=0, rd_reg_address=0, rd_reg_data=0, err_unexp_rsp=0, both queues empty. After reset, ld_issue_ready=1 and hazard_stall=0.
- Pending queue (PQ): FIFO of {rd, funct3, lsb}. Push on ld_issue_valid && ld_issue_ready.
- Return buffer (RB): FIFO of {rd, formatted data}.
- ld_issue_ready = (pq_cnt + rb_cnt) < DEPTH, combinational.
- ld_rsp_valid with PQ non-empty: pop the PQ head, format the data, push to RB in the same cycle. RB never overflows because of the capacity rule above.
- ld_rsp_valid with PQ empty: response ignored, err_unexp_rsp set to 1 until reset.
- Load with rd==0: consumes its PQ slot, and its response is discarded without an RB push.
- Formatting (byte select by lsb; half select by lsb[1]):
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 010 LW: word
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - any other funct3: treated as LW
- Write arbitration, outputs registered (1-cycle latency from the winning source):
  - alu_wr_en && alu_rd_addr!=0: ALU result written; RB holds.
  - else if RB non-empty: RB head popped and written.
  - else rd_reg_wr_en=0; address/data hold their previous values.
  - alu_wr_en with alu_rd_addr==0: no write, and the RB may pop that cycle.
- Simultaneous events: PQ push, PQ pop/RB push, and RB pop may all occur in one cycle; counts update by net change.
- hazard_stall (combinational) = 1 if any nonzero dec_rs1_addr/dec_rs2_addr/dec_rd_addr matches the rd of any valid PQ or RB entry. This covers RAW and WAW and keeps ALU writes from overtaking a pending load.
- hazard_stall also = 1 when a load is decoded while ld_issue_ready=0 (core qualifies with its own load decode).
- Reset mid-operation: all queue contents dropped, no further writes, and any subsequent responses count as unexpected.

Optional Feature:
- SC_CORE_OZ_WB_BYPASS_EN defined:
  - Adds outputs rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data.
  - rsN_fwd_valid=1 when rd_reg_wr_en=1 and rd_reg_address==dec_rsN_addr!=0; rsN_fwd_data=rd_reg_data.
  - hazard_stall still reflects queue contents only.
- Undefined: ports absent; core relies on RF write-before-read.

Test Plan:
- ALU only: alu_wr_en=1, rd=5, data=0x1234_5678 -> next cycle rd_reg_wr_en=1, address=5, data=0x1234_5678; with rd=0 -> no write.
- LB/LBU/LH: issue LB rd=3 lsb=2, respond 0x00F0_8000 -> x3=0xFFFF_FFF0; LBU same -> 0x0000_00F0; LH lsb=0 -> 0xFFFF_8000.
- Collision: ALU write rd=7 in the same cycle a buffered load (rd=9, 0xAA) is ready -> cycle N+1 writes x7, cycle N+2 writes x9=0xAA.
- Full: issue 4 loads with no response -> ld_issue_ready=0. One response -> still 0 until its RB write, then 1.
- Hazard: pending load rd=10; dec_rs2_addr=10 -> hazard_stall=1; dec_rs1_addr=0 with no other match -> 0. Stall clears the cycle after x10 is written.
- Error and reset: ld_rsp_valid with no load outstanding -> err_unexp_rsp=1 until reset. rst=0 with 2 loads pending -> queues cleared, ld_issue_ready=1, no RF writes.
